// File: rtl/radar_pulse_scheduler.sv
// Radar burst scheduler: launches num_pulses modulator waveforms spaced one PRI apart,
// watching the modulator's AXI4-Stream handshake for pulse end and PRI overruns.
module radar_pulse_scheduler #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned NP_W  = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] pri_cycles_i,
    input  logic [NP_W-1:0]  num_pulses_i,
    input  logic             tvalid_i,
    input  logic             tready_i,
    input  logic             tlast_i,
    output logic             mod_start_o,
    output logic             dds_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       err_o,
    output logic [NP_W-1:0]  pulse_cnt_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PULSE    = 2'd1;
    localparam logic [1:0] S_PRI_WAIT = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_pri_cnt;
    logic [CNT_W-1:0] r_pri_m1;
    logic [NP_W-1:0]  r_np;
    logic [NP_W-1:0]  r_pulse_cnt;
    logic [1:0]       r_err;
    logic             r_stop;
    logic             r_mod_start;
    logic             r_dds_en;
    logic             r_busy;
    logic             r_done;

    logic [1:0]       w_next_state;
    logic             w_launch;
    logic             w_start_ok;
    logic             w_cfg_err;
    logic             w_overrun;
    logic             w_stop_hold;
    logic             w_cfg_bad;
    logic             w_expire;
    logic             w_more;
    logic             w_pend;
    logic             w_stop_any;
    logic [NP_W-1:0]  w_cnt_base;

    assign w_cfg_bad  = (num_pulses_i == '0) || (pri_cycles_i < CNT_W'(2));
    assign w_expire   = (r_pri_cnt == r_pri_m1);
    assign w_more     = (r_pulse_cnt < r_np);
    assign w_pend     = tvalid_i & tready_i & tlast_i;
    assign w_stop_any = r_stop | stop_i;
    assign w_cnt_base = w_start_ok ? '0 : r_pulse_cnt;

    // Next-state decode; a pulse end coinciding with PRI expiry launches the next pulse directly
    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_start_ok   = 1'b0;
        w_cfg_err    = 1'b0;
        w_overrun    = 1'b0;
        w_stop_hold  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (w_cfg_bad) begin
                        w_cfg_err = 1'b1;
                    end else begin
                        w_start_ok   = 1'b1;
                        w_launch     = 1'b1;
                        w_next_state = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                if (w_pend) begin
                    if (w_stop_any) begin
                        w_next_state = S_DONE;
                    end else if (w_expire) begin
                        if (w_more) w_launch = 1'b1;
                        else        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_PRI_WAIT;
                    end
                end else if (w_expire) begin
                    w_overrun    = 1'b1;
                    w_next_state = S_DONE;
                end else begin
                    w_stop_hold = w_stop_any;
                end
            end
            S_PRI_WAIT: begin
                if (stop_i) begin
                    w_next_state = S_DONE;
                end else if (w_expire) begin
                    if (w_more) begin
                        w_launch     = 1'b1;
                        w_next_state = S_PULSE;
                    end else begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Burst datapath and registered status outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pri_cnt   <= '0;
            r_pri_m1    <= '0;
            r_np        <= '0;
            r_pulse_cnt <= '0;
            r_err       <= 2'b00;
            r_stop      <= 1'b0;
            r_mod_start <= 1'b0;
            r_dds_en    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_pri_m1 <= pri_cycles_i - CNT_W'(1);
                r_np     <= num_pulses_i;
            end
            if (w_launch)              r_pri_cnt <= '0;
            else if (r_state != S_IDLE) r_pri_cnt <= r_pri_cnt + CNT_W'(1);
            if (w_launch) r_pulse_cnt <= w_cnt_base + NP_W'(1);
            if (w_start_ok)     r_err <= 2'b00;
            else if (w_cfg_err) r_err <= r_err | 2'b01;
            else if (w_overrun) r_err <= r_err | 2'b10;
            r_stop      <= w_stop_hold;
            r_mod_start <= w_launch;
            r_dds_en    <= (w_next_state == S_PULSE) || (w_next_state == S_PRI_WAIT);
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (w_next_state == S_DONE);
        end
    end

    assign mod_start_o = r_mod_start;
    assign dds_en_o    = r_dds_en;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign pulse_cnt_o = r_pulse_cnt;

endmodule

// File: tb/tb_radar_pulse_scheduler.sv
// Bench for radar_pulse_scheduler: burst-level reference model checked every cycle,
// directed scenarios with literal timing expectations, then randomized traffic.
module tb_radar_pulse_scheduler;

    logic        clk_i = 1'b0;
    logic        reset_i, start_i, stop_i;
    logic [31:0] pri_cycles_i;
    logic [15:0] num_pulses_i;
    logic        tvalid_i, tready_i, tlast_i;
    logic        mod_start_o, dds_en_o, busy_o, done_o;
    logic [1:0]  err_o;
    logic [15:0] pulse_cnt_o;

    radar_pulse_scheduler dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .stop_i(stop_i),
        .pri_cycles_i(pri_cycles_i), .num_pulses_i(num_pulses_i),
        .tvalid_i(tvalid_i), .tready_i(tready_i), .tlast_i(tlast_i),
        .mod_start_o(mod_start_o), .dds_en_o(dds_en_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .pulse_cnt_o(pulse_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ms_q[$];
    int done_q[$];
    int resp_mode = 0;
    int resp_dly  = 4;

    // Inputs as seen by the DUT at the last rising edge
    logic        s_reset, s_start, s_stop, s_tv, s_tr, s_tl;
    logic [31:0] s_pri;
    logic [15:0] s_n;
    bit          s_seen = 1'b0;

    always @(posedge clk_i) begin
        cyc     <= cyc + 1;
        s_reset <= reset_i;
        s_start <= start_i;
        s_stop  <= stop_i;
        s_pri   <= pri_cycles_i;
        s_n     <= num_pulses_i;
        s_tv    <= tvalid_i;
        s_tr    <= tready_i;
        s_tl    <= tlast_i;
        s_seen  <= 1'b1;
    end

    // Burst-level model: is a burst running, is a waveform outstanding, how long since launch
    bit          m_active, m_wave, m_donecyc, m_stopreq;
    int unsigned m_age, m_pri, m_n;
    int          e_cnt;
    logic [1:0]  e_err;
    bit          e_mod, e_dds, e_busy, e_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit hs, expire, stop_any, launch, finish;
        launch = 1'b0;
        finish = 1'b0;
        hs = s_tv & s_tr & s_tl;
        if (s_reset) begin
            m_active = 0; m_wave = 0; m_donecyc = 0; m_stopreq = 0;
            e_err = 2'b00; e_cnt = 0;
        end else if (m_donecyc) begin
            m_donecyc = 0;
        end else if (!m_active) begin
            if (s_start) begin
                if (s_n == 0 || s_pri < 2) begin
                    e_err[0] = 1'b1;
                end else begin
                    m_pri = s_pri; m_n = s_n; e_err = 2'b00; e_cnt = 0;
                    m_active = 1; launch = 1;
                end
            end
        end else begin
            expire = (m_age == m_pri - 1);
            if (m_wave) begin
                stop_any = m_stopreq || s_stop;
                if (hs) begin
                    m_wave = 0;
                    if (stop_any)    finish = 1;
                    else if (expire) begin
                        if (e_cnt < int'(m_n)) launch = 1;
                        else                   finish = 1;
                    end
                end else if (expire) begin
                    e_err[1] = 1'b1;
                    finish = 1;
                end else begin
                    m_stopreq = stop_any;
                end
            end else if (s_stop) begin
                finish = 1;
            end else if (expire) begin
                if (e_cnt < int'(m_n)) launch = 1;
                else                   finish = 1;
            end
        end
        if (launch) begin
            e_cnt++; m_wave = 1; m_age = 0; m_stopreq = 0;
        end else begin
            m_age++;
        end
        if (finish) begin
            m_active = 0; m_wave = 0; m_stopreq = 0; m_donecyc = 1;
        end
        e_mod  = launch;
        e_dds  = m_active;
        e_busy = m_active || m_donecyc;
        e_done = m_donecyc;
    endtask

    // Per-cycle compare and event log
    initial begin
        forever begin
            @(negedge clk_i);
            if (s_seen) begin
                model_step();
                check("mod_start", 32'(mod_start_o), 32'(e_mod));
                check("dds_en",    32'(dds_en_o),    32'(e_dds));
                check("busy",      32'(busy_o),      32'(e_busy));
                check("done",      32'(done_o),      32'(e_done));
                check("err",       32'(err_o),       32'(e_err));
                check("pulse_cnt", 32'(pulse_cnt_o), 32'(16'(e_cnt)));
                if (mod_start_o === 1'b1) ms_q.push_back(cyc);
                if (done_o === 1'b1)      done_q.push_back(cyc);
            end
        end
    end

    // Modulator responder: handshake timing relative to each mod_start_o
    initial begin
        int age;
        age = 0;
        tvalid_i = 0; tready_i = 0; tlast_i = 0;
        forever begin
            @(negedge clk_i);
            if (mod_start_o === 1'b1) age = 0;
            else                      age++;
            tvalid_i = 0; tready_i = 0; tlast_i = 0;
            case (resp_mode)
                1: if (age == resp_dly) begin tvalid_i = 1; tready_i = 1; tlast_i = 1; end
                2: begin
                    tvalid_i = 1'($urandom % 2);
                    tready_i = 1'($urandom % 2);
                    tlast_i  = 1'($urandom % 4 == 0);
                end
                3: begin
                    if (age >= resp_dly - 3 && age < resp_dly) begin
                        tvalid_i = 1; tlast_i = 1;
                    end else if (age == resp_dly) begin
                        tvalid_i = 1; tready_i = 1; tlast_i = 1;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic go(input int pri, input int n);
        pri_cycles_i = 32'(pri);
        num_pulses_i = 16'(n);
        start_i = 1;
        tick();
        start_i = 0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            if (done_o === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic clear_log();
        ms_q.delete();
        done_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int c0, lim;
        reset_i = 1; start_i = 0; stop_i = 0;
        pri_cycles_i = 0; num_pulses_i = 0;
        repeat (3) tick();
        reset_i = 0;
        check("rst_busy", 32'(busy_o), 0);
        check("rst_cnt",  32'(pulse_cnt_o), 0);
        check("rst_err",  32'(err_o), 0);

        // Nominal burst; config inputs change right after the latch
        clear_log();
        resp_mode = 1; resp_dly = 4;
        c0 = cyc;
        pri_cycles_i = 10; num_pulses_i = 3; start_i = 1;
        tick();
        start_i = 0; pri_cycles_i = 3; num_pulses_i = 1;
        wait_done(200, ok);
        check("b1_done_seen", 32'(ok), 1);
        if (ms_q.size() == 3 && done_q.size() == 1) begin
            check("b1_first_launch", 32'(ms_q[0]), 32'(c0 + 1));
            check("b1_2nd_spacing",  32'(ms_q[1] - ms_q[0]), 10);
            check("b1_3rd_spacing",  32'(ms_q[2] - ms_q[0]), 20);
            check("b1_done_time",    32'(done_q[0] - ms_q[0]), 30);
        end else begin
            check("b1_launch_count", 32'(ms_q.size()), 3);
        end
        check("b1_cnt", 32'(pulse_cnt_o), 3);
        check("b1_err", 32'(err_o), 0);
        tick();

        // Invalid configurations
        clear_log();
        go(10, 0);
        check("cfg_n0_err",  32'(err_o), 1);
        check("cfg_n0_busy", 32'(busy_o), 0);
        go(1, 3);
        check("cfg_pri1_err",  32'(err_o), 1);
        check("cfg_pri1_busy", 32'(busy_o), 0);
        repeat (3) tick();
        check("cfg_no_launch", 32'(ms_q.size()), 0);

        // Overrun: handshake withheld
        clear_log();
        resp_mode = 0;
        go(8, 2);
        wait_done(100, ok);
        check("ovr_done_seen", 32'(ok), 1);
        if (ms_q.size() >= 1 && done_q.size() >= 1)
            check("ovr_done_time", 32'(done_q[0] - ms_q[0]), 8);
        check("ovr_launches", 32'(ms_q.size()), 1);
        check("ovr_err", 32'(err_o), 2);
        check("ovr_cnt", 32'(pulse_cnt_o), 1);
        tick();

        // Stop during the second pulse
        clear_log();
        resp_mode = 1; resp_dly = 6;
        go(20, 5);
        lim = 0;
        while (ms_q.size() < 2 && lim < 100) begin
            tick();
            lim++;
        end
        check("stp_second_seen", 32'(ms_q.size() >= 2), 1);
        repeat (2) tick();
        stop_i = 1;
        tick();
        stop_i = 0;
        wait_done(100, ok);
        check("stp_done_seen", 32'(ok), 1);
        if (ms_q.size() >= 2 && done_q.size() >= 1)
            check("stp_done_time", 32'(done_q[0] - ms_q[1]), 7);
        check("stp_cnt", 32'(pulse_cnt_o), 2);
        repeat (3) tick();
        check("stp_launches", 32'(ms_q.size()), 2);

        // Reset in PRI_WAIT, restart, and reset overriding start/stop
        clear_log();
        resp_mode = 1; resp_dly = 2;
        go(10, 3);
        repeat (5) tick();
        reset_i = 1;
        tick();
        reset_i = 0;
        check("rpw_busy", 32'(busy_o), 0);
        check("rpw_dds",  32'(dds_en_o), 0);
        check("rpw_cnt",  32'(pulse_cnt_o), 0);
        tick();
        go(10, 3);
        check("rpw_restart_mod", 32'(mod_start_o), 1);
        check("rpw_restart_cnt", 32'(pulse_cnt_o), 1);
        reset_i = 1; start_i = 1; stop_i = 1;
        tick();
        reset_i = 0; start_i = 0; stop_i = 0;
        check("rov_busy", 32'(busy_o), 0);
        tick();
        check("rov_still_idle", 32'(busy_o), 0);

        // tlast without tready must not end the pulse
        clear_log();
        resp_mode = 3; resp_dly = 6;
        go(20, 2);
        repeat (3) tick();
        stop_i = 1;
        tick();
        stop_i = 0;
        wait_done(100, ok);
        check("tl_done_seen", 32'(ok), 1);
        if (ms_q.size() >= 1 && done_q.size() >= 1)
            check("tl_done_time", 32'(done_q[0] - ms_q[0]), 7);
        check("tl_cnt", 32'(pulse_cnt_o), 1);
        tick();

        // Pulse end in the same cycle as PRI expiry
        clear_log();
        resp_mode = 1; resp_dly = 5;
        go(6, 2);
        wait_done(100, ok);
        check("co_done_seen", 32'(ok), 1);
        if (ms_q.size() == 2 && done_q.size() == 1) begin
            check("co_spacing",   32'(ms_q[1] - ms_q[0]), 6);
            check("co_done_time", 32'(done_q[0] - ms_q[0]), 12);
        end else begin
            check("co_launches", 32'(ms_q.size()), 2);
        end
        check("co_err", 32'(err_o), 0);
        tick();

        // Randomized traffic
        resp_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            reset_i      = ($urandom % 256 == 0);
            start_i      = ($urandom % 8 == 0);
            stop_i       = ($urandom % 32 == 0);
            pri_cycles_i = 32'($urandom_range(0, 12));
            num_pulses_i = 16'($urandom_range(0, 4));
            tick();
        end
        reset_i = 0; start_i = 0; stop_i = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/radar_pulse_scheduler.md
RADAR_PULSE_SCHEDULER -- requirements
Module: radar_pulse_scheduler

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of PRI counter and PRI config.
REQ-002 SHALL have parameter NP_W, default 16, width of pulse-count config and status.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle request to begin a burst; ignored unless state IDLE.
REQ-006 SHALL have port stop_i  input  1  one-cycle abort request.
REQ-007 SHALL have port pri_cycles_i  input  CNT_W  pulse repetition interval in clk_i cycles.
REQ-008 SHALL have port num_pulses_i  input  NP_W  pulses per burst.
REQ-009 SHALL have port tvalid_i, tready_i, tlast_i  input  1 each  monitored modulator AXI4-Stream handshake.
REQ-010 SHALL have port mod_start_o  output  1  one-cycle pulse launching one modulator waveform.
REQ-011 SHALL have port dds_en_o  output  1  DDS enable.
REQ-012 SHALL have port busy_o  output  1  high in any state except IDLE.
REQ-013 SHALL have port done_o  output  1  one-cycle burst-complete strobe.
REQ-014 SHALL have port err_o  output  2  sticky error: bit0 config invalid, bit1 PRI overrun.
REQ-015 SHALL have port pulse_cnt_o  output  NP_W  pulses launched in current/last burst.

Function
REQ-016 SHALL implement states IDLE, PULSE, PRI_WAIT, DONE.
REQ-017 In IDLE, start_i with num_pulses_i=0 or pri_cycles_i<2 SHALL set err_o[0], stay IDLE, launch nothing.
REQ-018 In IDLE, valid start_i SHALL latch pri_cycles_i/num_pulses_i, clear err_o and pulse_cnt_o, enter PULSE next cycle with mod_start_o=1 for exactly that cycle.
REQ-019 Config input changes after latch SHALL not affect the running burst.
REQ-020 Each mod_start_o SHALL increment pulse_cnt_o in the same cycle and reset PRI counter to 0; PRI counter SHALL increment every cycle while busy.
REQ-021 Pulse end = tvalid_i & tready_i & tlast_i in PULSE; SHALL move to PRI_WAIT next cycle; tlast_i without handshake SHALL be ignored.
REQ-022 In PRI_WAIT, when PRI counter = latched PRI-1: if pulse_cnt_o < latched count, SHALL re-enter PULSE with mod_start_o; else SHALL enter DONE.
REQ-023 Consecutive mod_start_o SHALL be spaced exactly latched PRI cycles apart.
REQ-024 If PRI counter reaches PRI-1 while in PULSE (no pulse end), SHALL set err_o[1] and enter DONE; pulse end in same cycle SHALL take priority (no error).
REQ-025 stop_i in PRI_WAIT SHALL enter DONE next cycle; stop_i in PULSE SHALL be latched and DONE entered after pulse end; stop_i in IDLE/DONE ignored.
REQ-026 stop_i coincident with a PRI expiry in PRI_WAIT SHALL win: no further mod_start_o.
REQ-027 DONE SHALL last one cycle with done_o=1, then IDLE; pulse_cnt_o and err_o held until next accepted start_i.
REQ-028 dds_en_o SHALL be 1 in PULSE and PRI_WAIT, 0 in IDLE and DONE.
REQ-029 start_i while busy SHALL be ignored with no error flag.

Reset
REQ-030 reset_i SHALL, at any state including mid-pulse, force IDLE next edge: mod_start_o=0, dds_en_o=0, busy_o=0, done_o=0, err_o=0, pulse_cnt_o=0, PRI counter=0, stop latch cleared.
REQ-031 reset_i SHALL override start_i and stop_i in the same cycle.

Verification
REQ-032 PRI=10, N=3, pulse end 4 cycles after each mod_start_o -> mod_start_o at t0, t0+10, t0+20; done_o at t0+30; pulse_cnt_o=3; err_o=0.
REQ-033 N=0 or PRI=1 with start_i -> err_o=01, busy_o stays 0, no mod_start_o.
REQ-034 PRI=8, N=2, tlast handshake withheld -> err_o=10 and done_o one cycle after counter hits 7; pulse_cnt_o=1.
REQ-035 PRI=20, N=5, stop_i mid second pulse -> done_o after that pulse's end; pulse_cnt_o=2; no third mod_start_o.
REQ-036 reset_i asserted in PRI_WAIT of a burst -> all outputs zero next cycle; new start_i then restarts with pulse_cnt_o=1.
REQ-037 tlast_i=1 with tready_i=0 for 3 cycles, then handshake -> PRI_WAIT entered only after handshake cycle.
